// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: natural-to-zigzag table, transpose helper and component ids.
// The zigzag table lists the natural (row*8+col) index visited at each zigzag position.
package jpeg_pkg;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_e;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Buffer is filled column-major, so a natural index r*8+c lives at c*8+r.
  function automatic logic [5:0] tr(input logic [5:0] n);
    return {n[2:0], n[5:3]};
  endfunction

endpackage

// File: rtl/zigzag_lut.sv
// Combinational map from zigzag position k to column-major buffer address.
// Pure ROM, no state.
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] k,
  output logic [5:0] addr
);

  always_comb begin
    addr = tr(ZZ[k]);
  end

endmodule

// File: rtl/zigzag_dcpred.sv
// Ping-pong 8x8 reorder buffer (column-major in, zigzag out) with per-component DC prediction.
// Output burst starts 2 cycles after the 64th write; no input backpressure, output never stalls.
module zigzag_dcpred
  import jpeg_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         q_en,
  input  logic [W-1:0] q,
  input  logic [1:0]   blk_comp,
  input  logic         frame_start,
  output logic         o_en,
  output logic [W:0]   o_data,
  output logic         o_sop,
  output logic         o_eop,
  output logic [1:0]   o_comp
);

  logic [W-1:0] mem_q [2][64];

  logic [5:0] wcnt_q, wcnt_d;
  logic       wb_q, wb_d, rb_q, rb_d;
  logic [1:0] full_q, full_d;
  logic [1:0] comp_q [2];
  logic [1:0] comp_d [2];

  rd_state_e  state_q, state_d;
  logic [5:0] k_q, k_d;
  logic       rd_act;
  logic [5:0] rd_addr;

  logic         rd_vld_q, rd_vld_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic [1:0]   rd_comp_q, rd_comp_d;
  logic [W-1:0] rd_dat_q, rd_dat_d;

  logic signed [W-1:0] pred_q [3];
  logic signed [W-1:0] pred_d [3];
  logic         o_en_q, o_en_d, o_sop_q, o_sop_d, o_eop_q, o_eop_d;
  logic [W:0]   o_data_q, o_data_d;
  logic [1:0]   o_comp_q, o_comp_d;
  logic [W:0]   dc_ext, pred_ext;

  zigzag_lut u_lut (
    .k    (k_q),
    .addr (rd_addr)
  );

  always_comb begin
    wcnt_d  = wcnt_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    full_d  = full_q;
    comp_d  = comp_q;
    state_d = state_q;
    k_d     = k_q;
    rd_act  = 1'b0;

    if (q_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd0) comp_d[wb_q] = blk_comp;
      if (wcnt_q == 6'd63) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end

    // IDLE issues k=0 itself so a newly filled bank is read on the very next cycle.
    case (state_q)
      S_IDLE: begin
        if (full_q[rb_q]) begin
          rd_act  = 1'b1;
          k_d     = 6'd1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_act = 1'b1;
        k_d    = k_q + 6'd1;
        if (k_q == 6'd63) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          state_d      = full_q[~rb_q] ? S_READ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_vld_d  = rd_act;
    rd_sop_d  = rd_act && (k_q == 6'd0);
    rd_eop_d  = rd_act && (k_q == 6'd63);
    rd_comp_d = comp_q[rb_q];
    rd_dat_d  = mem_q[rb_q][rd_addr];
  end

  always_comb begin
    dc_ext   = {rd_dat_q[W-1], rd_dat_q};
    pred_ext = frame_start ? '0 : {pred_q[rd_comp_q][W-1], pred_q[rd_comp_q]};
    pred_d   = pred_q;
    if (frame_start) pred_d = '{default: '0};
    if (rd_vld_q && rd_sop_q) pred_d[rd_comp_q] = rd_dat_q;

    o_en_d   = rd_vld_q;
    o_sop_d  = rd_vld_q && rd_sop_q;
    o_eop_d  = rd_vld_q && rd_eop_q;
    o_comp_d = rd_vld_q ? rd_comp_q : o_comp_q;
    o_data_d = '0;
    if (rd_vld_q) o_data_d = rd_sop_q ? (dc_ext - pred_ext) : dc_ext;
  end

  always_ff @(posedge clk) begin
    if (q_en) mem_q[wb_q][wcnt_q] <= q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      full_q    <= '0;
      comp_q    <= '{default: '0};
      state_q   <= S_IDLE;
      k_q       <= '0;
      rd_vld_q  <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
      rd_comp_q <= '0;
      rd_dat_q  <= '0;
      pred_q    <= '{default: '0};
      o_en_q    <= 1'b0;
      o_sop_q   <= 1'b0;
      o_eop_q   <= 1'b0;
      o_comp_q  <= '0;
      o_data_q  <= '0;
    end else begin
      if (q_en) assert (!full_q[wb_q]);
      wcnt_q    <= wcnt_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      full_q    <= full_d;
      comp_q    <= comp_d;
      state_q   <= state_d;
      k_q       <= k_d;
      rd_vld_q  <= rd_vld_d;
      rd_sop_q  <= rd_sop_d;
      rd_eop_q  <= rd_eop_d;
      rd_comp_q <= rd_comp_d;
      rd_dat_q  <= rd_dat_d;
      pred_q    <= pred_d;
      o_en_q    <= o_en_d;
      o_sop_q   <= o_sop_d;
      o_eop_q   <= o_eop_d;
      o_comp_q  <= o_comp_d;
      o_data_q  <= o_data_d;
    end
  end

  assign o_en   = o_en_q;
  assign o_sop  = o_sop_q;
  assign o_eop  = o_eop_q;
  assign o_comp = o_comp_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_zigzag_dcpred.sv
// Directed bench for zigzag_dcpred: captured output events are compared against hand-derived values.
module tb_zigzag_dcpred;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_en;
  logic [11:0] q;
  logic [1:0]  blk_comp;
  logic        frame_start;
  logic        o_en;
  logic [12:0] o_data;
  logic        o_sop, o_eop;
  logic [1:0]  o_comp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last;
  int t_first;

  typedef struct {
    logic signed [12:0] d;
    logic               sop;
    logic               eop;
    logic [1:0]         comp;
    int                 cyc;
  } ev_t;
  ev_t mon[$];

  // Ramp block (q=n) seen in zigzag order.
  int exp_ramp [64] = '{
    0,  8,  1,  2,  9,  16, 24, 17, 10, 3,  4,  11, 18, 25, 32, 40,
    33, 26, 19, 12, 5,  6,  13, 20, 27, 34, 41, 48, 56, 49, 42, 35,
    28, 21, 14, 7,  15, 22, 29, 36, 43, 50, 57, 58, 51, 44, 37, 30,
    23, 31, 38, 45, 52, 59, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
  };

  zigzag_dcpred #(.W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .q_en        (q_en),
    .q           (q),
    .blk_comp    (blk_comp),
    .frame_start (frame_start),
    .o_en        (o_en),
    .o_data      (o_data),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_comp      (o_comp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_en) mon.push_back('{d: $signed(o_data), sop: o_sop, eop: o_eop, comp: o_comp, cyc: cyc});
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ramp=1: q=n for n>0; ramp=0: AC all zero. n=0 always carries dc.
  task automatic write_block(input int dc, input bit ramp, input logic [1:0] comp, input int gap);
    for (int n = 0; n < 64; n++) begin
      if (n > 0) begin
        for (int g = 0; g < gap; g++) begin
          q_en = 1'b0;
          tick();
        end
      end
      q_en     = 1'b1;
      q        = (n == 0) ? 12'(dc) : (ramp ? 12'(n) : 12'd0);
      blk_comp = comp;
      tick();
    end
    t_last = cyc;
  endtask

  task automatic wait_out(input int n, input int budget);
    int b;
    b = 0;
    while (mon.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (mon.size() < n) chk("timeout", mon.size(), n);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; q_en = 1'b0; q = '0; blk_comp = '0; frame_start = 1'b0;
    repeat (3) tick();
    chk("rst_o_en", o_en, 0);
    chk("rst_o_data", $signed(o_data), 0);
    chk("rst_o_sop", o_sop, 0);
    chk("rst_o_eop", o_eop, 0);
    chk("rst_o_comp", o_comp, 0);
    rst = 1'b0;
    tick();

    // Ramp block
    mon.delete();
    write_block(0, 1'b1, 2'd0, 0);
    q_en = 1'b0;
    wait_out(64, 200);
    repeat (5) tick();
    chk("ramp_count", mon.size(), 64);
    if (mon.size() >= 64) begin
      for (int i = 0; i < 64; i++) chk("ramp_val", mon[i].d, exp_ramp[i]);
      chk("ramp_sop_cyc", mon[0].cyc, t_last + 2);
      chk("ramp_sop", mon[0].sop, 1);
      chk("ramp_eop_cyc", mon[63].cyc, t_last + 65);
      chk("ramp_eop", mon[63].eop, 1);
      chk("ramp_eop_early", mon[62].eop, 0);
      chk("ramp_comp", mon[10].comp, 0);
    end

    // DC prediction across components
    mon.delete();
    write_block(100, 1'b0, 2'd0, 0);
    write_block(90, 1'b0, 2'd0, 0);
    write_block(50, 1'b0, 2'd1, 0);
    write_block(-20, 1'b0, 2'd0, 0);
    q_en = 1'b0;
    wait_out(256, 600);
    if (mon.size() >= 256) begin
      chk("dc0", mon[0].d, 100);
      chk("dc1", mon[64].d, -10);
      chk("dc2", mon[128].d, 50);
      chk("dc3", mon[192].d, -110);
      chk("dc_ac_zero", mon[130].d, 0);
      chk("dc_cb_comp", mon[150].comp, 1);
      chk("dc_cb_sop", mon[128].sop, 1);
    end

    // Extremes after a predictor clear
    mon.delete();
    pulse_frame_start();
    write_block(-2048, 1'b0, 2'd0, 0);
    write_block(2047, 1'b0, 2'd0, 0);
    q_en = 1'b0;
    wait_out(128, 400);
    if (mon.size() >= 128) begin
      chk("ext_min", mon[0].d, -2048);
      chk("ext_max", mon[64].d, 4095);
    end

    // Back-to-back: q_en high for 192 cycles
    mon.delete();
    write_block(0, 1'b1, 2'd0, 0);
    write_block(0, 1'b1, 2'd0, 0);
    write_block(0, 1'b1, 2'd0, 0);
    q_en = 1'b0;
    wait_out(192, 500);
    if (mon.size() >= 192) begin
      chk("b2b_span", mon[191].cyc - mon[0].cyc, 191);
      chk("b2b_eop0", mon[63].eop, 1);
      chk("b2b_sop1", mon[64].sop, 1);
      chk("b2b_adj1", mon[64].cyc - mon[63].cyc, 1);
      chk("b2b_eop1", mon[127].eop, 1);
      chk("b2b_sop2", mon[128].sop, 1);
      chk("b2b_dc0", mon[0].d, -2047);
      chk("b2b_dc1", mon[64].d, 0);
      chk("b2b_val", mon[129].d, 8);
      chk("b2b_last", mon[191].d, 63);
    end

    // Sparse input, 1 write in 3 cycles
    mon.delete();
    write_block(0, 1'b1, 2'd0, 2);
    q_en = 1'b0;
    wait_out(64, 200);
    if (mon.size() >= 64) begin
      chk("sparse_start", mon[0].cyc, t_last + 2);
      chk("sparse_span", mon[63].cyc - mon[0].cyc, 63);
      for (int i = 0; i < 64; i += 7) chk("sparse_val", mon[i].d, exp_ramp[i]);
      chk("sparse_eop", mon[63].eop, 1);
    end

    // frame_start between two Y blocks
    mon.delete();
    write_block(100, 1'b0, 2'd0, 0);
    q_en = 1'b0;
    wait_out(64, 200);
    tick();
    pulse_frame_start();
    write_block(90, 1'b0, 2'd0, 0);
    q_en = 1'b0;
    wait_out(128, 200);
    if (mon.size() >= 128) begin
      chk("fs_first", mon[0].d, 100);
      chk("fs_second", mon[64].d, 90);
    end

    // Reset mid-burst with a partial block pending
    mon.delete();
    write_block(5, 1'b0, 2'd0, 0);
    for (int n = 0; n < 30; n++) begin
      q_en = 1'b1;
      q    = 12'd500;
      tick();
    end
    q_en = 1'b0;
    chk("mid_burst_active", o_en, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_o_en", o_en, 0);
    chk("mid_rst_o_data", $signed(o_data), 0);
    chk("mid_rst_o_sop", o_sop, 0);
    rst = 1'b0;
    tick();
    mon.delete();
    write_block(77, 1'b1, 2'd0, 0);
    q_en = 1'b0;
    t_first = t_last;
    wait_out(64, 200);
    repeat (80) tick();
    chk("rst_count", mon.size(), 64);
    if (mon.size() >= 64) begin
      chk("rst_dc", mon[0].d, 77);
      chk("rst_start", mon[0].cyc, t_first + 2);
      chk("rst_ac1", mon[1].d, 8);
      chk("rst_ac63", mon[63].d, 63);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigzag_dcpred.md
# zigzag_dcpred

Reorders quantized 8x8 coefficient blocks from column-major order into JPEG zigzag order and replaces each block's DC term with its difference from the previous DC of the same component. It sits directly downstream of the quantizer and consumes its `q_en`/`q` stream one coefficient per cycle. It feeds the run-length/Huffman stage a gap-free, framed 64-coefficient burst per block, and uses a ping-pong buffer to absorb bursty input.

## Interface
- `W`, default 12: signed coefficient width; equals quantizer output width (`W_QUANTO`+1).
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `q_en`  in  1: one coefficient valid this cycle; no backpressure is available.
- `q`  in  W: signed coefficient. Input index n=0..63 within a block maps to row n%8, column n/8 (column-major).
- `blk_comp`  in  2: component id (0=Y, 1=Cb, 2=Cr). Sampled with coefficient n=0; 3 is illegal.
- `frame_start`  in  1: one-cycle pulse that clears all DC predictors. Legal only between blocks (input counter at 0).
- `o_en`  out  1: output coefficient valid.
- `o_data`  out  W+1: signed output. k=0 carries the DC difference; k>0 carries the AC value, sign-extended.
- `o_sop`  out  1: asserted with k=0.
- `o_eop`  out  1: asserted with k=63.
- `o_comp`  out  2: component id of the block being output; held constant for the whole burst.

## Operation
- Buffer: two banks of 64xW (bank 0 and bank 1), plus a 6-bit write counter `wcnt` and a 1-bit write-bank pointer `wb`.
- Write path: on `q_en`, store `q` at address `wcnt` in bank `wb`, then increment `wcnt`. When `wcnt`=0, latch `blk_comp` into `comp[wb]`. When `wcnt`=63, wrap to 0, set `full[wb]`, and toggle `wb`.
- Read FSM states:
  - IDLE → READ when `full[rb]` is set.
  - READ: a 6-bit `k` runs 0..63. Each cycle, issue read address `tr(zz[k])`, where zz is the standard JPEG zigzag table (natural index r*8+c) and tr(r*8+c)=c*8+r.
  - At k=63: clear `full[rb]` and toggle `rb`. If the other bank is already full, stay in READ with k=0 (back-to-back); otherwise go to IDLE.
- Overflow is impossible at no more than 1 input per cycle, so no overflow flag exists. A write into a bank whose `full` bit is set is a protocol violation and is flagged in simulation by an assertion only.
- DC prediction: `pred[0..2]` are W-bit signed registers. At output k=0: `o_data` = sext(dc) − sext(`pred[comp]`), computed in W+1 bits (no overflow possible), and `pred[comp]` ← dc.
- `frame_start` clears all predictors. If it coincides with a k=0 output, the subtraction uses 0 and the predictor is then loaded with dc. `frame_start` does not disturb buffered data or the FSM.
- Reset values:
  - `o_en`=0, `o_data`=0, `o_sop`=0, `o_eop`=0, `o_comp`=0.
  - `wcnt`=0, `wb`=`rb`=0, `full`=0, FSM in IDLE, `pred`=0.
  - A partially written block is discarded.

## Timing
- RAM read is registered; the DC subtraction and output register add one more stage.
- Latency: the `q_en` write of n=63 at cycle T gives the first read address at T+1 and `o_en`/`o_sop` at T+2. `o_eop` follows at T+65.
- Output bursts are exactly 64 consecutive `o_en` cycles with no internal gaps, whatever the input spacing.
- With continuous input, output is continuous: `o_en` stays high across block boundaries, and `o_eop` is followed directly by the next `o_sop`.
- Reset asserted mid-burst: all outputs are 0 in the cycle after `rst` is sampled.
- Same-cycle write and read on one bank cannot occur, because reads only touch full banks.

## Structure
- Shared package `jpeg_pkg`: constant `ZZ[64]` (natural→zigzag table), function `tr()`, component enum.
- Sub-module `zigzag_lut`: combinational k→read-address map (64x6 ROM built from `ZZ`/`tr`).
- Banks are two plain 64xW register arrays, or one 128xW simple dual-port RAM addressed {bank, addr}.

## Test plan
- Ramp: one Y block with `q`=n (n=0..63), `pred`=0 → `o_data` sequence 0,8,1,2,9,16,24,17,10,3,…,63. `o_sop` at T+2, `o_eop` at T+65, `o_comp`=0.
- DC prediction: Y with DC 100, Y with DC 90, Cb with DC 50, Y with DC −20 (all AC 0) → DC outputs 100, −10, 50, −110.
- Extremes: Y with DC −2048, then Y with DC 2047 → outputs −2048, then 4095 (13-bit, no wrap).
- Back-to-back: 3 blocks with `q_en` held high for 192 cycles → `o_en` high for 192 consecutive cycles, with `o_eop`/`o_sop` adjacent at each boundary.
- Sparse input: `q_en` 1-in-3 cycles → identical output values, each block emitted as a contiguous 64-cycle burst starting 2 cycles after its 64th write.
- `frame_start` between Y blocks with DC 100 and 90 → second output is 90. Reset after 30 writes, then a full block → only the full block is output and `pred` is 0.
